// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp encodings and op-class helpers for the
// decoder, the ALU and the mul/div unit.
package alu_pkg;

  localparam int CODE_W = 5;
  typedef logic [CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD    = 5'd0;
  localparam alu_code_t ALU_SUB    = 5'd1;
  localparam alu_code_t ALU_AND    = 5'd2;
  localparam alu_code_t ALU_OR     = 5'd3;
  localparam alu_code_t ALU_XOR    = 5'd4;
  localparam alu_code_t ALU_SLT    = 5'd5;
  localparam alu_code_t ALU_SLTU   = 5'd6;
  localparam alu_code_t ALU_SLL    = 5'd7;
  localparam alu_code_t ALU_SRL    = 5'd8;
  localparam alu_code_t ALU_SRA    = 5'd9;
  localparam alu_code_t ALU_MUL    = 5'd10;
  localparam alu_code_t ALU_MULH   = 5'd11;
  localparam alu_code_t ALU_MULHSU = 5'd12;
  localparam alu_code_t ALU_MULHU  = 5'd13;
  localparam alu_code_t ALU_DIV    = 5'd14;
  localparam alu_code_t ALU_DIVU   = 5'd15;
  localparam alu_code_t ALU_REM    = 5'd16;
  localparam alu_code_t ALU_REMU   = 5'd17;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_t;

  function automatic logic op_is_mul(input alu_code_t c);
    return (c >= ALU_MUL) && (c <= ALU_MULHU);
  endfunction

  function automatic logic op_is_div(input alu_code_t c);
    return (c >= ALU_DIV) && (c <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/funct decode into an ALU control code, with
// legality and multi-cycle class (lat_sel: 0 = mul, 1 = div).
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output alu_code_t  code,
  output logic       illegal,
  output logic       multi,
  output logic       lat_sel
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: code = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: code = ALU_SUB;
          3'b100, 3'b101: code = ALU_SLT;
          3'b110, 3'b111: code = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      ALUOP_RI: begin
        if (op5 && funct7b0) begin
          // RV32M space: only legal when the extension is built in.
          if (EN_M) begin
            case (funct3)
              3'b000:  code = ALU_MUL;
              3'b001:  code = ALU_MULH;
              3'b010:  code = ALU_MULHSU;
              3'b011:  code = ALU_MULHU;
              3'b100:  code = ALU_DIV;
              3'b101:  code = ALU_DIVU;
              3'b110:  code = ALU_REM;
              default: code = ALU_REMU;
            endcase
          end else begin
            illegal = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end
      end
      ALUOP_RSVD: illegal = 1'b1;
    endcase
  end

  assign multi   = ~illegal & (op_is_mul(code) | op_is_div(code));
  assign lat_sel = op_is_div(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder that sequences multi-cycle MUL/DIV ops with a
// latency counter, a valid/ready handshake and a core stall.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic              op5,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              out_valid,
  output logic              illegal,
  output logic              stall
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam bit MUL_MC  = (MUL_LAT > 1);
  localparam bit DIV_MC  = (DIV_LAT > 1);
  // BUSY lasts LAT-1 cycles and out_valid follows the terminal count.
  localparam logic [CNT_W-1:0] MUL_LOAD = MUL_MC ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = DIV_MC ? CNT_W'(DIV_LAT - 2) : '0;

  alu_code_t dec_code;
  logic      dec_illegal;
  logic      dec_multi;
  logic      dec_lat_sel;

  alu_op_decode #(
    .EN_M(EN_M)
  ) u_decode (
    .alu_op  (ALUOp),
    .op5     (op5),
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .funct7b0(funct7b0),
    .code    (dec_code),
    .illegal (dec_illegal),
    .multi   (dec_multi),
    .lat_sel (dec_lat_sel)
  );

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              vld_q, vld_d;
  logic              accept;
  logic              go_multi;

  assign in_ready = (state_q == ST_IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign go_multi = dec_multi && (dec_lat_sel ? DIV_MC : MUL_MC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    vld_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        ctrl_d    = CTRL_W'(dec_code);
        illegal_d = dec_illegal;
        if (go_multi) begin
          state_d = ST_BUSY;
          cnt_d   = dec_lat_sel ? DIV_LOAD : MUL_LOAD;
        end else begin
          vld_d = 1'b1;
        end
      end
    end else begin
      // Flush outranks the terminal count: the op is dropped silently.
      if (flush) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        state_d = ST_IDLE;
        vld_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      vld_q     <= vld_d;
    end
  end

  assign alu_ctrl  = ctrl_q;
  // A flush in the completion cycle still cancels the result.
  assign out_valid = vld_q && !flush;
  assign illegal   = illegal_q;
  assign stall     = (state_q == ST_BUSY);

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the single-cycle ALU decoder.
- Decodes ALUOp/funct3/funct7/op5 into a wider ALU control code covering full RV32I plus optional RV32M.
- Sequences multi-cycle MUL/DIV ops with a latency counter and a valid/ready handshake. Raises a stall to the core while an iterative op is in flight.
- Sits between main_decoder and the ALU/muldiv datapath.

Parameters:
- CTRL_W, 5, width of alu_ctrl (minimum 5).
- EN_M, 1, 1 enables RV32M decode; 0 flags M encodings illegal.
- MUL_LAT, 3, cycles for MUL/MULH/MULHSU/MULHU (1 means single-cycle).
- DIV_LAT, 32, cycles for DIV/DIVU/REM/REMU (1 means single-cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decode request.
- in_ready  out  1  block can accept a request (state IDLE).
- ALUOp  in  2  00 mem, 01 branch, 10 R/I-type, 11 reserved.
- op5  in  1  opcode bit 5 (1 = R-type).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  funct7 bit 5.
- funct7b0  in  1  funct7 bit 0 (M-extension select).
- flush  in  1  abort the current/pending op.
- alu_ctrl  out  CTRL_W  registered ALU control code.
- out_valid  out  1  one-cycle pulse: op complete, alu_ctrl result valid.
- illegal  out  1  qualifies out_valid: encoding unsupported.
- stall  out  1  high while in BUSY.

Behaviour:
- Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17. Codes 18 and above are unused.
- Decode (combinational, internal):
  - ALUOp 00 -> ADD.
  - ALUOp 01, by funct3: 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
  - ALUOp 10 with op5 & funct7b0 (RV32M): if EN_M, funct3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; if EN_M=0, illegal.
  - ALUOp 10 otherwise, by funct3: 000 -> SUB if op5&funct7b5, else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if funct7b5, else SRL; 110 OR; 111 AND.
  - ALUOp 11 -> illegal.
  - Any illegal decode yields code ADD with illegal=1.
- State machine: IDLE, BUSY.
  - in_ready = (state==IDLE) & ~flush.
  - Accept occurs when in_valid & in_ready.
  - On accept, alu_ctrl and illegal are registered (visible next cycle). alu_ctrl holds its value until the next accept.
  - Single-cycle op (non-M, illegal, or LAT<=1): out_valid=1 on the cycle after accept; stay IDLE. Back-to-back accepts are allowed every cycle.
  - Multi-cycle op: go to BUSY and load cnt=LAT-2; stall=1.
  - In BUSY, cnt decrements each cycle. When cnt==0, return to IDLE with out_valid=1 on the following cycle. Total accept-to-out_valid latency = LAT cycles.
  - Counter width = clog2(max(MUL_LAT,DIV_LAT)) + 1. No wrap: cnt never decrements below 0.
- flush:
  - In BUSY: go to IDLE next cycle; no out_valid; stall drops.
  - Flush wins over the terminal count and over in_valid in the same cycle.
  - Flush in the cycle after a single-cycle accept suppresses that out_valid.
- Reset, async asserted: state IDLE; alu_ctrl=0; out_valid=0; illegal=0; stall=0; cnt=0. in_ready=1 once rst deasserts.
- Reset mid-BUSY: the op is discarded; no out_valid.
- in_valid while BUSY is ignored. The requester must hold the request until in_ready.

Decomposition:
- Shared package alu_pkg holds the ALU control code localparams (ALU_ADD .. ALU_REMU), ALUOp encodings, and an op_is_mul/op_is_div helper function. The ALU and muldiv unit reuse this package.
- Natural sub-module: alu_op_decode, a pure combinational decode producing {code, illegal, multi, lat_sel}. alu_ctrl_seq wraps it with the FSM and counter.

Test Plan:
- Reset: rst=0 with in_valid=1 -> alu_ctrl=0, out_valid=0, stall=0. After release, in_ready=1.
- R-type sweep, back-to-back, one request per cycle: ALUOp=10, op5=1, funct7b5=1, funct3=000 -> SUB; funct3=101 -> SRA. Each gives out_valid exactly 1 cycle after its accept. Branch funct3=110 -> SLTU. ALUOp=11 -> illegal=1, alu_ctrl=0.
- MUL, MUL_LAT=3: funct7b0=1, op5=1, funct3=000 -> alu_ctrl=10; stall high 2 cycles; out_valid 3 cycles after accept; in_ready low during BUSY.
- DIVU, DIV_LAT=32: funct3=101 -> code 15. A second in_valid during BUSY is not accepted. out_valid at accept+32; the next request is accepted the cycle after.
- Flush at the terminal count of DIV -> no out_valid; IDLE next cycle. Flush simultaneous with in_valid in IDLE -> no accept.
- EN_M=0 build: MUL encoding -> single-cycle, illegal=1, no stall.
